// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C register-file target.
// Latency: n/a (declarations only).
// Backpressure: n/a; the I2C bus has no flow control beyond ACK/NACK.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_REG_ADDR,
    ST_REG_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_state_t;

  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises SCL/SDA into clk and flags SCL edges plus START/STOP conditions.
// Latency: events are visible 2 clk after a pin change and act on the 3rd edge.
// Backpressure: none; events are single-cycle pulses that are never held.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic o_sda
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_prev;
  logic       r_sda_prev;
  logic       w_scl;
  logic       w_sda;

  // Two-flop synchronisers followed by one history stage for edge detection.
  // Reset to the idle-bus level so reset itself never looks like START/STOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i_scl};
      r_sda_sync <= {r_sda_sync[0], i_sda};
      r_scl_prev <= r_scl_sync[1];
      r_sda_prev <= r_sda_sync[1];
    end
  end

  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];

  assign scl_rise  =  w_scl & ~r_scl_prev;
  assign scl_fall  = ~w_scl &  r_scl_prev;
  // SCL must be high on both samples so an SDA change near an SCL edge is not misread.
  assign start_det =  w_scl & r_scl_prev &  r_sda_prev & ~w_sda;
  assign stop_det  =  w_scl & r_scl_prev & ~r_sda_prev &  w_sda;
  assign o_sda     =  w_sda;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with a NUM_REGS x 8 register file; optional I2C_TGT_AUTOINC_EN makes the pointer auto-increment.
// Latency: SDA_out updates 1 clk after a detected SCL fall; wr_strobe 1 clk after the 8th data-bit SCL rise.
// Backpressure: none; the target always ACKs a matched address and every written byte.
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         NUM_REGS = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        SCL,
  input  logic                        SDA_in,
  output logic                        SDA_out,
  output logic                        wr_strobe,
  output logic [$clog2(NUM_REGS)-1:0] wr_addr,
  output logic [7:0]                  wr_data,
  output logic                        busy
);

  localparam int PW = $clog2(NUM_REGS);

  i2c_state_t    r_state;
  i2c_state_t    w_state_nxt;
  logic [2:0]    r_bit_cnt;
  logic [2:0]    w_bit_cnt_nxt;
  logic [6:0]    r_shift;
  logic          w_shift_en;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic [7:0]    r_regs [NUM_REGS];
  logic          r_sda_out;
  logic          w_sda_out_nxt;
  logic          r_busy;
  logic          w_busy_nxt;
  logic          r_wr_stb;
  logic          w_wr_en;
  logic [PW-1:0] r_wr_addr;
  logic [7:0]    r_wr_data;

  logic          w_scl_rise;
  logic          w_scl_fall;
  logic          w_start;
  logic          w_stop;
  logic          w_sda;
  logic [7:0]    w_byte;
  logic [7:0]    w_rd_byte;
  logic          w_match;

  i2c_line_sync u_line_sync (
    .clk       (clk),
    .rst       (rst),
    .i_scl     (SCL),
    .i_sda     (SDA_in),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start),
    .stop_det  (w_stop),
    .o_sda     (w_sda)
  );

  // The byte as it stands once the bit on the current SCL rise is included.
  assign w_byte    = {r_shift, w_sda};
  assign w_rd_byte = r_regs[r_ptr];
  assign w_match   = (w_byte[7:1] == DEV_ADDR);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: START/STOP outrank bit-level progress in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = ST_DEV_ADDR;
    end else if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else if (w_scl_rise) begin
      case (r_state)
        ST_DEV_ADDR: if (r_bit_cnt == 3'd7) w_state_nxt = w_match ? ST_DEV_ACK : ST_IGNORE;
        ST_DEV_ACK:  w_state_nxt = (r_shift[0] == I2C_RW_WRITE) ? ST_REG_ADDR : ST_RD_DATA;
        ST_REG_ADDR: if (r_bit_cnt == 3'd7) w_state_nxt = ST_REG_ACK;
        ST_REG_ACK:  w_state_nxt = ST_WR_DATA;
        ST_WR_DATA:  if (r_bit_cnt == 3'd7) w_state_nxt = ST_WR_ACK;
        ST_WR_ACK:   w_state_nxt = ST_WR_DATA;
        ST_RD_DATA:  if (r_bit_cnt == 3'd7) w_state_nxt = ST_RD_ACK;
        ST_RD_ACK:   w_state_nxt = (w_sda == I2C_NACK) ? ST_IGNORE : ST_RD_DATA;
        default:     w_state_nxt = r_state;
      endcase
    end
  end

  // Output/datapath decode: SDA drive changes on SCL fall, bits are taken on SCL rise.
  always_comb begin
    w_sda_out_nxt = r_sda_out;
    w_busy_nxt    = r_busy;
    w_wr_en       = 1'b0;
    w_ptr_nxt     = r_ptr;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_en    = 1'b0;
    if (w_start) begin
      w_sda_out_nxt = 1'b1;
      w_bit_cnt_nxt = 3'd0;
    end else if (w_stop) begin
      w_sda_out_nxt = 1'b1;
      w_busy_nxt    = 1'b0;
      w_bit_cnt_nxt = 3'd0;
    end else begin
      if (w_scl_fall) begin
        case (r_state)
          ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK: w_sda_out_nxt = I2C_ACK;
          ST_RD_DATA: w_sda_out_nxt = w_rd_byte[3'd7 - r_bit_cnt];
          default:    w_sda_out_nxt = 1'b1;
        endcase
      end
      if (w_scl_rise) begin
        case (r_state)
          ST_DEV_ADDR: begin
            w_shift_en    = 1'b1;
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) w_busy_nxt = w_match;
          end
          ST_REG_ADDR: begin
            w_shift_en    = 1'b1;
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) w_ptr_nxt = w_byte[PW-1:0];
          end
          ST_WR_DATA: begin
            w_shift_en    = 1'b1;
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_wr_en = 1'b1;
`ifdef I2C_TGT_AUTOINC_EN
              w_ptr_nxt = r_ptr + 1'b1;
`endif
            end
          end
          ST_RD_DATA: w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          ST_RD_ACK: begin
            w_bit_cnt_nxt = 3'd0;
            if (w_sda == I2C_NACK) begin
              w_busy_nxt = 1'b0;
            end else begin
`ifdef I2C_TGT_AUTOINC_EN
              w_ptr_nxt = r_ptr + 1'b1;
`endif
            end
          end
          default: w_bit_cnt_nxt = 3'd0;
        endcase
      end
    end
  end

  // Datapath registers; reset also clears the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt <= 3'd0;
      r_shift   <= 7'd0;
      r_ptr     <= '0;
      r_sda_out <= 1'b1;
      r_busy    <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
    end else begin
      r_bit_cnt <= w_bit_cnt_nxt;
      r_ptr     <= w_ptr_nxt;
      r_sda_out <= w_sda_out_nxt;
      r_busy    <= w_busy_nxt;
      r_wr_stb  <= w_wr_en;
      if (w_shift_en) r_shift <= w_byte[6:0];
      if (w_wr_en) begin
        r_regs[r_ptr] <= w_byte;
        r_wr_addr     <= r_ptr;
        r_wr_data     <= w_byte;
      end
    end
  end

  assign SDA_out   = r_sda_out;
  assign busy      = r_busy;
  assign wr_strobe = r_wr_stb;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;

endmodule

// File: tb/tb_i2c_target_regfile.sv
`timescale 1ns/1ps
// Bus-level bench for i2c_target_regfile: a bit-banged master plus a write scoreboard.
module tb_i2c_target_regfile;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda = 1'b1;
  logic       sda_out;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  always #5 clk = ~clk;

  i2c_target_regfile #(.DEV_ADDR(7'h50), .NUM_REGS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .SCL       (scl),
    .SDA_in    (sda),
    .SDA_out   (sda_out),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  logic [11:0] exp_q[$];
  logic [11:0] exp_head;
  logic        quiet_en   = 1'b0;
  int          quiet_viol = 0;

  // Scoreboard: every wr_strobe pops the oldest expected {addr,data}.
  always @(negedge clk) begin
    if (quiet_en && (sda_out !== 1'b1 || busy !== 1'b0)) quiet_viol++;
    if (!rst && wr_strobe === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL wr_unexpected: got addr=%0h data=%02h, required no write", wr_addr, wr_data);
      end else begin
        exp_head = exp_q.pop_front();
        if ({wr_addr, wr_data} !== exp_head) begin
          n_bad++;
          $display("FAIL wr_event: got addr=%0h data=%02h, required addr=%0h data=%02h",
                   wr_addr, wr_data, exp_head[11:8], exp_head[7:0]);
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Works both from an idle bus and as a repeated START with SCL low.
  task automatic bus_start();
    sda = 1'b1; wait_clk(6);
    scl = 1'b1; wait_clk(10);
    sda = 1'b0; wait_clk(10);
    scl = 1'b0; wait_clk(4);
  endtask

  task automatic bus_stop();
    sda = 1'b0; wait_clk(6);
    scl = 1'b1; wait_clk(10);
    sda = 1'b1; wait_clk(10);
  endtask

  task automatic put_bit(input logic b);
    sda = b;    wait_clk(6);
    scl = 1'b1; wait_clk(10);
    scl = 1'b0; wait_clk(4);
  endtask

  task automatic get_bit(output logic b);
    sda = 1'b1; wait_clk(6);
    scl = 1'b1; wait_clk(5);
    b = sda_out; wait_clk(5);
    scl = 1'b0; wait_clk(4);
  endtask

  task automatic put_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(v[i]);
    get_bit(ack);
  endtask

  task automatic get_byte(input logic ack_bit, output logic [7:0] v);
    for (int i = 7; i >= 0; i--) get_bit(v[i]);
    put_bit(ack_bit);
  endtask

  // Register write of n bytes (byte 0 first); expected writes go to the scoreboard.
  task automatic wr_txn(input logic [7:0] reg_b, input int n, input logic [23:0] dat,
                        output logic [4:0] acks);
    logic [3:0] ptr;
    logic [7:0] b;
    acks = '0;
    bus_start();
    put_byte(8'hA0, acks[0]);
    put_byte(reg_b, acks[1]);
    ptr = reg_b[3:0];
    for (int i = 0; i < n; i++) begin
      b = dat[8*i +: 8];
      exp_q.push_back({ptr, b});
`ifdef I2C_TGT_AUTOINC_EN
      ptr = ptr + 4'd1;
`endif
      put_byte(b, acks[2+i]);
    end
    bus_stop();
  endtask

  // Random read: set pointer, repeated START, read n bytes, NACK on the last.
  task automatic rd_txn(input logic [7:0] reg_b, input int n,
                        output logic [23:0] got, output logic [2:0] acks);
    logic [7:0] b;
    got = '0;
    bus_start();
    put_byte(8'hA0, acks[0]);
    put_byte(reg_b, acks[1]);
    bus_start();
    put_byte(8'hA1, acks[2]);
    for (int i = 0; i < n; i++) begin
      get_byte((i == n - 1) ? 1'b1 : 1'b0, b);
      got[8*i +: 8] = b;
    end
    bus_stop();
  endtask

  task automatic test_reset();
    rst = 1'b1; wait_clk(4);
    rst = 1'b0; wait_clk(3);
    n_total++; if (sda_out !== 1'b1)  begin n_bad++; $display("FAIL reset_sda: got %b, required 1", sda_out); end
    n_total++; if (wr_strobe !== 1'b0) begin n_bad++; $display("FAIL reset_strobe: got %b, required 0", wr_strobe); end
    n_total++; if (wr_addr !== 4'h0)  begin n_bad++; $display("FAIL reset_addr: got %h, required 0", wr_addr); end
    n_total++; if (wr_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h, required 00", wr_data); end
    n_total++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    bus_start();
    put_byte(8'hA0, a0);
    n_total++; if (busy !== 1'b1) begin n_bad++; $display("FAIL write_busy: got %b, required 1", busy); end
    put_byte(8'h03, a1);
    exp_q.push_back({4'h3, 8'h5A});
    put_byte(8'h5A, a2);
    bus_stop();
    n_total++; if ({a0, a1, a2} !== 3'b000) begin n_bad++; $display("FAIL write_acks: got %b, required 000", {a0, a1, a2}); end
    n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL write_busy_stop: got %b, required 0", busy); end
    n_total++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL write_missing: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_random_read();
    logic [23:0] got;
    logic [2:0]  acks;
    rd_txn(8'h03, 1, got, acks);
    n_total++; if (acks !== 3'b000) begin n_bad++; $display("FAIL rread_acks: got %b, required 000", acks); end
    n_total++; if (got[7:0] !== 8'h5A) begin n_bad++; $display("FAIL rread_data: got %h, required 5a", got[7:0]); end
  endtask

  task automatic test_burst();
    logic [4:0]  wacks;
    logic [23:0] got;
    logic [2:0]  acks;
    logic [23:0] exp_rb;
    wr_txn(8'h0F, 3, {8'h33, 8'h22, 8'h11}, wacks);
    n_total++; if (wacks !== 5'b00000) begin n_bad++; $display("FAIL burst_acks: got %b, required 00000", wacks); end
    n_total++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL burst_missing: got %0d pending, required 0", exp_q.size()); end
`ifdef I2C_TGT_AUTOINC_EN
    exp_rb = {8'h33, 8'h22, 8'h11};
`else
    exp_rb = {8'h00, 8'h00, 8'h33};
`endif
    rd_txn(8'h0F, 1, got, acks);
    n_total++; if (got[7:0] !== exp_rb[7:0]) begin n_bad++; $display("FAIL burst_reg15: got %h, required %h", got[7:0], exp_rb[7:0]); end
    rd_txn(8'h00, 1, got, acks);
    n_total++; if (got[7:0] !== exp_rb[15:8]) begin n_bad++; $display("FAIL burst_reg0: got %h, required %h", got[7:0], exp_rb[15:8]); end
    rd_txn(8'h01, 1, got, acks);
    n_total++; if (got[7:0] !== exp_rb[23:16]) begin n_bad++; $display("FAIL burst_reg1: got %h, required %h", got[7:0], exp_rb[23:16]); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] got;
    logic [2:0]  acks;
    logic [23:0] exp_rb;
`ifdef I2C_TGT_AUTOINC_EN
    exp_rb = {8'h33, 8'h22, 8'h11};
`else
    exp_rb = {8'h33, 8'h33, 8'h33};
`endif
    rd_txn(8'h0F, 3, got, acks);
    n_total++; if (acks !== 3'b000) begin n_bad++; $display("FAIL seqread_acks: got %b, required 000", acks); end
    n_total++; if (got !== exp_rb) begin n_bad++; $display("FAIL seqread_data: got %h, required %h", got, exp_rb); end
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    quiet_viol = 0;
    quiet_en = 1'b1;
    bus_start();
    put_byte(8'hB0, a0);
    put_byte(8'h00, a1);
    bus_stop();
    quiet_en = 1'b0;
    n_total++; if ({a0, a1} !== 2'b11) begin n_bad++; $display("FAIL mismatch_acks: got %b, required 11", {a0, a1}); end
    n_total++; if (quiet_viol != 0) begin n_bad++; $display("FAIL mismatch_quiet: got %0d active cycles, required 0", quiet_viol); end
  endtask

  task automatic test_abort();
    logic a0, a1;
    logic [23:0] got;
    logic [2:0]  acks;
    bus_start();
    put_byte(8'hA0, a0);
    put_byte(8'h02, a1);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
    bus_stop();
    n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b, required 0", busy); end
    rd_txn(8'h02, 1, got, acks);
    n_total++; if (got[7:0] !== 8'h00) begin n_bad++; $display("FAIL abort_reg2: got %h, required 00", got[7:0]); end
  endtask

  task automatic test_rst_read();
    logic [4:0]  wacks;
    logic        a, b0, b1;
    logic [23:0] got;
    logic [2:0]  acks;
    wr_txn(8'h05, 1, {16'h0000, 8'h0F}, wacks);
    bus_start();
    put_byte(8'hA0, a);
    put_byte(8'h05, a);
    bus_start();
    put_byte(8'hA1, a);
    get_bit(b0);
    get_bit(b1);
    n_total++; if ({b0, b1, sda_out, busy} !== 4'b0001) begin
      n_bad++; $display("FAIL rst_pre: got bits=%b%b sda=%b busy=%b, required bits=00 sda=0 busy=1", b0, b1, sda_out, busy);
    end
    rst = 1'b1;
    wait_clk(1);
    n_total++; if (sda_out !== 1'b1) begin n_bad++; $display("FAIL rst_sda: got %b, required 1", sda_out); end
    n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
    rst = 1'b0;
    scl = 1'b1; sda = 1'b1;
    wait_clk(20);
    rd_txn(8'h05, 1, got, acks);
    n_total++; if (got[7:0] !== 8'h00) begin n_bad++; $display("FAIL rst_reg5: got %h, required 00", got[7:0]); end
    rd_txn(8'h03, 1, got, acks);
    n_total++; if (got[7:0] !== 8'h00) begin n_bad++; $display("FAIL rst_reg3: got %h, required 00", got[7:0]); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_random_read();
    test_burst();
    test_back_to_back();
    test_mismatch();
    test_abort();
    test_rst_read();
    wait_clk(10);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
